// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with one-cycle done pulse at expiry and optional auto-reload.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] reload, reload_n, count_n;
    logic             done_n;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            done   <= done_n;
        end
    end
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        done_n   = 1'b0;
        if (load) begin
            count_n  = load_data;
            reload_n = load_data;
            state_n  = (load_data != '0) ? RUN : IDLE;
        end else if (abort) begin
            state_n = IDLE;
        end else if (state == RUN && enable) begin
            if (count == WIDTH'(1)) begin
                done_n  = 1'b1;
                count_n = auto_reload ? reload : '0;
                state_n = auto_reload ? RUN : IDLE;
            end else begin
                count_n = count - WIDTH'(1);
            end
        end
    end
    assign zero = (count == '0);
    assign busy = (state == RUN);
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: randomized and directed scoreboard bench against a behavioural timer model.
module tb_down_counter_timer;
    logic       clk = 0;
    logic       reset = 0, load = 0, enable = 0, auto_reload = 0, abort = 0;
    logic [3:0] load_data = 0;
    logic [3:0] count;
    logic       zero, busy, done;

    typedef struct packed {
        logic [3:0] c;
        logic       z, b, d;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0, cyc = 0;
    int   m_count = 0, m_reload = 0;
    bit   m_run = 0, m_done = 0;

    down_counter_timer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .load(load), .load_data(load_data),
        .enable(enable), .auto_reload(auto_reload), .abort(abort),
        .count(count), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL cyc=%0d %s: got %0d expected %0d", cyc, name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("count", int'(count), int'(e.c));
            check("zero", int'(zero), int'(e.z));
            check("busy", int'(busy), int'(e.b));
            check("done", int'(done), int'(e.d));
        end
    end

    // One timer tick: remaining ticks run down to expiry, then restart from the period or stop.
    task automatic step(input bit r, input bit ld, input int d, input bit en, input bit ar, input bit ab);
        @(negedge clk);
        reset = r; load = ld; load_data = 4'(d); enable = en; auto_reload = ar; abort = ab;
        m_done = 0;
        if (!r) begin
            m_count = 0; m_reload = 0; m_run = 0;
        end else if (ld) begin
            m_count = d; m_reload = d; m_run = (d != 0);
        end else if (ab) begin
            m_run = 0;
        end else if (m_run && en) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_done = 1;
                if (ar) m_count = m_reload;
                else m_run = 0;
            end
        end
        q.push_back('{c: 4'(m_count), z: (m_count == 0), b: m_run, d: m_done});
    endtask

    initial begin
        step(0, 1, 9, 0, 0, 0);
        step(0, 1, 9, 0, 0, 0);
        step(1, 1, 13, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0, 0);
        step(1, 1, 3, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 0);
        step(1, 1, 5, 1, 0, 0);
        for (int i = 0; i < 14; i++) step(1, 0, 0, (i % 3) != 0, 0, 0);
        step(1, 1, 7, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0, 0);
        step(1, 1, 7, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 0);
        step(1, 1, 9, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0);
        step(1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(31) != 0, $urandom_range(7) == 0, $urandom_range(15),
                 $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(15) == 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter/timer; the counting-down complement to the team's loadable up-counter, sharing its load/load_data style.
- Counts a loaded value down to zero and raises a one-cycle `done` pulse at expiry.
- Optionally auto-reloads to generate periodic ticks.
- Used as a timeout and periodic-event source alongside the up-counter in the same clock domain.

Parameters:
- WIDTH, 4, bit width of count, load_data and the internal reload register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset: sampled at the clk rising edge, reset asserted when low.
- load  input  1  load request; captures load_data on the clk edge.
- load_data  input  WIDTH  start and reload value.
- enable  input  1  count-enable; decrement only when high.
- auto_reload  input  1  1 = reload at expiry and keep running; 0 = stop at zero.
- abort  input  1  stop the timer, holding count.
- count  output  WIDTH  current count value (registered).
- zero  output  1  combinational, count == 0.
- busy  output  1  high while state == RUN.
- done  output  1  registered, one-cycle expiry pulse.

Behaviour:
- Reset (reset == 0 at posedge):
  - count = 0, reload register = 0, state = IDLE.
  - done = 0, busy = 0, zero = 1.
  - Overrides all other inputs.
- State machine, two states:
  - IDLE: count holds.
  - RUN: counting down.
- Priority per edge, highest first: reset, load, abort, terminal/decrement, hold.
- load = 1:
  - count <= load_data and reload register <= load_data, from any state.
  - Next state is RUN if load_data != 0; otherwise IDLE.
  - done <= 0.
  - load beats a simultaneous terminal event: no done pulse that edge.
- abort = 1 (no load): state <= IDLE, count holds, done <= 0.
- RUN with enable = 0: count holds, done <= 0. No timeout on enable.
- RUN with enable = 1 and count > 1: count <= count - 1, done <= 0.
- RUN with enable = 1 and count == 1 (terminal), done <= 1 for exactly one cycle:
  - auto_reload = 0: count <= 0, state <= IDLE.
  - auto_reload = 1: count <= reload register, state stays RUN; count never shows 0.
- Period: in auto-reload mode, done repeats every N enabled cycles, N = reload value. N = 1 gives done every enabled cycle.
- Latency: with enable held high, done rises on the N-th clock edge after the load edge (load value N).
- IDLE:
  - count holds; enable and auto_reload are ignored.
  - done is 0 on every edge except the terminal edge itself.
- No wrap-around: count never decrements below 0 and never goes 0 -> all-ones.
- auto_reload is sampled only on the terminal edge; changing it mid-run affects only the next expiry.
- Reset mid-run: immediate return to reset values; a pending expiry is discarded and done stays 0.
- Outputs `zero` and `busy` derive from registered state only, so there is no combinational path from inputs.

Test Plan:
- Reset: hold reset = 0 for 2 edges with load = 1, load_data = 4'h9 -> count = 0, zero = 1, busy = 0, done = 0.
- One-shot: load 4'hD, enable = 1, auto_reload = 0 -> count D, C, …, 1, 0 on successive edges:
  - done high for exactly one cycle on the 13th edge after load;
  - busy falls on that same edge;
  - count stays 0 afterwards.
- Auto-reload: load 4'h3, auto_reload = 1, enable = 1 -> count 3, 2, 1, 3, 2, 1, …; done pulses every 3rd edge; zero never asserts.
- Enable gating: load 4'h5, toggle enable 1, 0, 0, 1, … -> count decrements only on enable edges; done after 5 enabled edges.
- Collisions: load 4'h7 on the terminal edge -> count = 7, done = 0, busy = 1. abort at count 4 -> count holds 4, busy = 0; enable is ignored until the next load.
- Reset mid-run at count 6 -> count 0, done 0. Then load 4'h0 -> state IDLE, no done, zero = 1.
